// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter slice: op codes, default widths and a
// constant-friendly log2 used to size index fields.
package alu_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int CTRL_W_DEFAULT = 4;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1110;

  // Never returns less than 1 so that a 1-bit index field is always legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >>> 1) begin
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/alu.sv
// Plain combinational ALU shared by the arbiter's requesters.
// Undefined op codes produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CTRL_W = CTRL_W_DEFAULT
) (
  input  logic [DATA_W-1:0] operand1,
  input  logic [DATA_W-1:0] operand2,
  input  logic [CTRL_W-1:0] control,
  output logic [DATA_W-1:0] result
);

  localparam int SHW = clog2(DATA_W);

  always_comb begin
    result = '0;
    case (control)
      ALU_AND: result = operand1 & operand2;
      ALU_OR:  result = operand1 | operand2;
      ALU_ADD: result = operand1 + operand2;
      ALU_SUB: result = operand1 - operand2;
      ALU_SLT: result[0] = $signed(operand1) < $signed(operand2);
      ALU_NOR: result = ~(operand1 | operand2);
      ALU_SLL: result = operand1 << operand2[SHW-1:0];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request at or after ptr
// (wrapping) wins. It holds no state; the pointer lives in the caller.
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between NUM_REQ requesters through a
// round-robin grant and a two-stage (operand, result) registered pipeline.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int CTRL_W  = CTRL_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_op1,
  input  logic [NUM_REQ*DATA_W-1:0] req_op2,
  input  logic [NUM_REQ*CTRL_W-1:0] req_ctrl,
  output logic [NUM_REQ-1:0]        resp_valid,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [DATA_W-1:0]         resp_result,
  output logic [DATA_W-1:0]         alu_operand1,
  output logic [DATA_W-1:0]         alu_operand2,
  output logic [CTRL_W-1:0]         alu_control,
  input  logic [DATA_W-1:0]         alu_result
);

  localparam int IDW = clog2(NUM_REQ);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. Grant never looks at any ready, so valid never depends on ready.

  logic              s1_valid;
  logic [DATA_W-1:0] s1_op1;
  logic [DATA_W-1:0] s1_op2;
  logic [CTRL_W-1:0] s1_ctrl;
  logic [IDW-1:0]    s1_id;

  logic              s2_valid;
  logic [DATA_W-1:0] s2_result;
  logic [IDW-1:0]    s2_id;

  logic [IDW-1:0]    rr_ptr;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_idx;
  logic               grant_any;

  logic s2_free;
  logic s1_free;
  logic hs;

  logic [DATA_W-1:0] sel_op1;
  logic [DATA_W-1:0] sel_op2;
  logic [CTRL_W-1:0] sel_ctrl;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (IDW)
  ) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign s2_free = !s2_valid || resp_ready[s2_id];
  assign s1_free = !s1_valid || s2_free;
  // rst_n gates ready so nothing looks accepted while reset is asserted.
  assign hs        = grant_any && s1_free && rst_n;
  assign req_ready = grant & {NUM_REQ{s1_free && rst_n}};

  always_comb begin
    sel_op1  = '0;
    sel_op2  = '0;
    sel_ctrl = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_op1  = req_op1[i*DATA_W +: DATA_W];
        sel_op2  = req_op2[i*DATA_W +: DATA_W];
        sel_ctrl = req_ctrl[i*CTRL_W +: CTRL_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op1   <= '0;
      s1_op2   <= '0;
      s1_ctrl  <= '0;
      s1_id    <= '0;
    end else if (s1_free) begin
      s1_valid <= hs;
      if (hs) begin
        s1_op1  <= sel_op1;
        s1_op2  <= sel_op2;
        s1_ctrl <= sel_ctrl;
        s1_id   <= grant_idx;
      end
    end
  end

  // s2 captures the ALU output of whatever s1 holds whenever it has room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_id     <= '0;
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= alu_result;
        s2_id     <= s1_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (hs) begin
      rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDW'(1);
    end
  end

  assign alu_operand1 = s1_valid ? s1_op1  : '0;
  assign alu_operand2 = s1_valid ? s1_op2  : '0;
  assign alu_control  = s1_valid ? s1_ctrl : '0;

  always_comb begin
    resp_valid = '0;
    if (s2_valid) resp_valid[s2_id] = 1'b1;
  end

  assign resp_result = s2_valid ? s2_result : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter with the real ALU attached and
// a queue-based reference model of in-flight operations.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;
  localparam int CTRL_W  = 4;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_op1;
  logic [NUM_REQ*DATA_W-1:0] req_op2;
  logic [NUM_REQ*CTRL_W-1:0] req_ctrl;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [NUM_REQ-1:0]        resp_ready;
  logic [DATA_W-1:0]         resp_result;
  logic [DATA_W-1:0]         alu_operand1;
  logic [DATA_W-1:0]         alu_operand2;
  logic [CTRL_W-1:0]         alu_control;
  logic [DATA_W-1:0]         alu_result;

  logic [DATA_W-1:0] op1 [NUM_REQ];
  logic [DATA_W-1:0] op2 [NUM_REQ];
  logic [CTRL_W-1:0] ctl [NUM_REQ];

  int checks;
  int failures;

  // Reference model: ops in flight, oldest first, with their pipeline stage.
  int                ptr;
  logic [DATA_W-1:0] exp_q [$];
  int                id_q  [$];
  int                stg_q [$];
  logic [DATA_W-1:0] a_q   [$];
  logic [DATA_W-1:0] b_q   [$];
  logic [CTRL_W-1:0] c_q   [$];

  logic [CTRL_W-1:0] codes [8];

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  always_comb begin
    req_op1  = '0;
    req_op2  = '0;
    req_ctrl = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_op1[i*DATA_W +: DATA_W]  = op1[i];
      req_op2[i*DATA_W +: DATA_W]  = op2[i];
      req_ctrl[i*CTRL_W +: CTRL_W] = ctl[i];
    end
  end

  alu_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .CTRL_W  (CTRL_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .req_ctrl     (req_ctrl),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_result  (resp_result),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_control  (alu_control),
    .alu_result   (alu_result)
  );

  alu #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_alu (
    .operand1 (alu_operand1),
    .operand2 (alu_operand2),
    .control  (alu_control),
    .result   (alu_result)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_alu(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [CTRL_W-1:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      4'b1110: return a << (b % 32);
      default: return '0;
    endcase
  endfunction

  // One cycle: inputs are already set after a falling edge; check, clock, update model.
  task automatic step();
    logic [NUM_REQ-1:0] e_rv;
    logic [NUM_REQ-1:0] e_rr;
    logic [DATA_W-1:0]  e_res;
    logic [DATA_W-1:0]  e_a;
    logic [DATA_W-1:0]  e_b;
    logic [CTRL_W-1:0]  e_c;
    int g;
    int idx;
    bit drain;
    bit acc;
    #2;
    e_rv = '0; e_rr = '0; e_res = '0; e_a = '0; e_b = '0; e_c = '0;
    drain = 1'b0; g = -1;
    if (exp_q.size() > 0 && stg_q[0] == 2) begin
      e_rv[id_q[0]] = 1'b1;
      e_res = exp_q[0];
      drain = resp_ready[id_q[0]];
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (stg_q[i] == 1) begin
        e_a = a_q[i]; e_b = b_q[i]; e_c = c_q[i];
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (ptr + k) % NUM_REQ;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    acc = (g >= 0) && ((exp_q.size() - int'(drain)) < 2);
    if (acc) e_rr[g] = 1'b1;
    check_eq("req_ready",    32'(req_ready),    32'(e_rr));
    check_eq("resp_valid",   32'(resp_valid),   32'(e_rv));
    check_eq("resp_result",  resp_result,       e_res);
    check_eq("alu_operand1", alu_operand1,      e_a);
    check_eq("alu_operand2", alu_operand2,      e_b);
    check_eq("alu_control",  32'(alu_control),  32'(e_c));
    @(posedge clk);
    if (drain) begin
      void'(exp_q.pop_front()); void'(id_q.pop_front()); void'(stg_q.pop_front());
      void'(a_q.pop_front());   void'(b_q.pop_front());  void'(c_q.pop_front());
    end
    if (exp_q.size() > 0) stg_q[0] = 2;
    if (acc) begin
      exp_q.push_back(ref_alu(op1[g], op2[g], ctl[g]));
      id_q.push_back(g);
      stg_q.push_back(1);
      a_q.push_back(op1[g]);
      b_q.push_back(op2[g]);
      c_q.push_back(ctl[g]);
      ptr = (g + 1) % NUM_REQ;
    end
    @(negedge clk);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_req_ready",  32'(req_ready),   32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid),  32'd0);
    check_eq("rst_resp_result", resp_result,     32'd0);
    check_eq("rst_alu_op1",    alu_operand1,     32'd0);
    check_eq("rst_alu_ctrl",   32'(alu_control), 32'd0);
    exp_q.delete(); id_q.delete(); stg_q.delete();
    a_q.delete(); b_q.delete(); c_q.delete();
    ptr = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int r, input logic [CTRL_W-1:0] c,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    ctl[r] = c; op1[r] = a; op2[r] = b;
  endtask

  task automatic rand_req(input int r);
    if ($urandom_range(0, 9) == 0) ctl[r] = 4'($urandom_range(0, 15));
    else ctl[r] = codes[$urandom_range(0, 7)];
    op1[r] = $urandom();
    op2[r] = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 40));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0; failures = 0; ptr = 0;
    codes[0] = ALU_AND; codes[1] = ALU_OR;  codes[2] = ALU_ADD; codes[3] = ALU_SUB;
    codes[4] = ALU_SLT; codes[5] = ALU_NOR; codes[6] = ALU_SLL; codes[7] = 4'b0011;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, '0, '0, '0);
    rst_n = 1'b0;
    req_valid = 2'b11;
    resp_ready = 2'b11;
    #3;
    check_eq("reset_req_ready",  32'(req_ready),  32'd0);
    check_eq("reset_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("reset_alu_op2",    alu_operand2,    32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b00;

    // ADD 5,7 on requester 0: result 12 two cycles after the handshake.
    set_req(0, ALU_ADD, 32'd5, 32'd7);
    req_valid = 2'b01;
    #1 check_eq("add_req_ready", 32'(req_ready), 32'b01);
    step();
    req_valid = 2'b00;
    step();
    #1;
    check_eq("add_resp_valid",  32'(resp_valid), 32'b01);
    check_eq("add_resp_result", resp_result,      32'd12);
    step();
    step();

    // Both requesters from reset: requester 0 first, then requester 1.
    do_reset();
    set_req(0, ALU_SUB, 32'd3, 32'd5);
    set_req(1, ALU_SLL, 32'd1, 32'd33);
    req_valid = 2'b11;
    step();
    step();
    req_valid = 2'b00;
    #1;
    check_eq("sub_resp_valid",  32'(resp_valid), 32'b01);
    check_eq("sub_resp_result", resp_result,      32'hFFFF_FFFE);
    step();
    #1;
    check_eq("sll_resp_valid",  32'(resp_valid), 32'b10);
    check_eq("sll_resp_result", resp_result,      32'd2);
    step();
    step();

    // Six back-to-back cycles with both valid and full acceptance.
    for (int c = 0; c < 6; c++) begin
      rand_req(0);
      rand_req(1);
      req_valid = 2'b11;
      step();
    end
    req_valid = 2'b00;
    for (int c = 0; c < 3; c++) step();

    // Stall requester 0's responses while it streams SLT ops.
    resp_ready = 2'b10;
    req_valid = 2'b01;
    for (int c = 0; c < 4; c++) begin
      set_req(0, ALU_SLT, $urandom(), $urandom());
      if (c >= 2) begin
        #1 check_eq("stall_req_ready", 32'(req_ready), 32'd0);
      end
      step();
    end
    resp_ready = 2'b11;
    for (int c = 0; c < 3; c++) begin
      set_req(0, ALU_SLT, $urandom(), $urandom());
      step();
    end
    req_valid = 2'b00;
    for (int c = 0; c < 3; c++) step();

    // Reset with both stages full; no stale response afterwards.
    resp_ready = 2'b00;
    req_valid = 2'b11;
    rand_req(0);
    rand_req(1);
    step();
    step();
    step();
    do_reset();
    resp_ready = 2'b11;
    #1 check_eq("post_rst_grant", 32'(req_ready), 32'b01);
    step();
    req_valid = 2'b00;
    for (int c = 0; c < 3; c++) step();

    // Undefined op code on requester 1 returns zero.
    do_reset();
    set_req(1, 4'b0011, 32'd9, 32'd9);
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    step();
    #1;
    check_eq("undef_resp_valid",  32'(resp_valid), 32'b10);
    check_eq("undef_resp_result", resp_result,      32'd0);
    step();

    // Random traffic with random backpressure and occasional resets.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      req_valid = 2'($urandom_range(0, 3));
      resp_ready[0] = ($urandom_range(0, 3) != 0);
      resp_ready[1] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) rand_req(0);
      if ($urandom_range(0, 2) != 0) rand_req(1);
      step();
    end
    req_valid = 2'b00;
    resp_ready = 2'b11;
    for (int c = 0; c < 4; c++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
